// File: rtl/spi_cmd_scheduler.sv
// Two-requester round-robin command scheduler in front of an SPI master.
// Grants one command at a time, waits for the master handshake, returns the
// received word (or an abort marker on timeout) and enforces an idle gap.
module spi_cmd_scheduler #(
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned GAP_CYCLES     = 4
) (
   input  logic        spi_clk_i,
   input  logic        spi_rst_i,
   input  logic        req0_valid_i,
   input  logic [47:0] req0_data_i,
   input  logic [1:0]  req0_div_i,
   input  logic        req0_fbo_i,
   output logic        req0_ack_o,
   input  logic        req1_valid_i,
   input  logic [47:0] req1_data_i,
   input  logic [1:0]  req1_div_i,
   input  logic        req1_fbo_i,
   output logic        req1_ack_o,
   output logic        rsp0_valid_o,
   output logic        rsp1_valid_o,
   output logic [47:0] rsp_data_o,
   output logic        rsp_err_o,
   output logic        m_start_o,
   output logic [47:0] m_data_o,
   output logic [1:0]  m_div_o,
   output logic        m_fbo_o,
   input  logic        m_done_i,
   input  logic [47:0] m_rx_i,
   output logic        busy_o
);

   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
   localparam logic [47:0] RSP_ABORT = {48{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_DONE,
      S_RESP,
      S_GAP
   } state_t;

   state_t      r_state;
   logic        r_arm;      // blocks a grant on the first edge after reset release
   logic        r_last;     // id of the requester granted most recently
   logic        r_gnt_id;   // id of the requester owning the transaction in flight
   logic [15:0] r_tmo_cnt;
   logic [15:0] r_gap_cnt;

   logic w_gnt_any;
   logic w_gnt1;
   logic w_tmo_hit;

   // A tie goes to whichever requester was not granted last.
   assign w_gnt_any = r_arm & (req0_valid_i | req1_valid_i);
   assign w_gnt1    = req1_valid_i & (~req0_valid_i | ~r_last);
   assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
   assign busy_o    = (r_state != S_IDLE);

   // Scheduler FSM with all outputs registered; async reset aborts any transaction.
   always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
      if (!spi_rst_i) begin
         r_state      <= S_IDLE;
         r_arm        <= 1'b0;
         r_last       <= 1'b1;
         r_gnt_id     <= 1'b0;
         r_tmo_cnt    <= 16'd0;
         r_gap_cnt    <= 16'd0;
         req0_ack_o   <= 1'b0;
         req1_ack_o   <= 1'b0;
         rsp0_valid_o <= 1'b0;
         rsp1_valid_o <= 1'b0;
         rsp_data_o   <= RSP_ABORT;
         rsp_err_o    <= 1'b0;
         m_start_o    <= 1'b0;
         m_data_o     <= 48'd0;
         m_div_o      <= 2'd0;
         m_fbo_o      <= 1'b0;
      end else begin
         r_arm        <= 1'b1;
         req0_ack_o   <= 1'b0;
         req1_ack_o   <= 1'b0;
         rsp0_valid_o <= 1'b0;
         rsp1_valid_o <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_gnt_any) begin
                  r_state   <= S_ISSUE;
                  r_gnt_id  <= w_gnt1;
                  r_last    <= w_gnt1;
                  r_tmo_cnt <= 16'd0;
                  m_start_o <= 1'b1;
                  if (w_gnt1) begin
                     m_data_o   <= req1_data_i;
                     m_div_o    <= req1_div_i;
                     m_fbo_o    <= req1_fbo_i;
                     req1_ack_o <= 1'b1;
                  end else begin
                     m_data_o   <= req0_data_i;
                     m_div_o    <= req0_div_i;
                     m_fbo_o    <= req0_fbo_i;
                     req0_ack_o <= 1'b1;
                  end
               end
            end
            S_ISSUE, S_WAIT_DONE: begin
               r_tmo_cnt <= r_tmo_cnt + 16'd1;
               if (w_tmo_hit) begin
                  r_state      <= S_RESP;
                  m_start_o    <= 1'b0;
                  rsp_data_o   <= RSP_ABORT;
                  rsp_err_o    <= 1'b1;
                  rsp0_valid_o <= ~r_gnt_id;
                  rsp1_valid_o <= r_gnt_id;
               end else if ((r_state == S_ISSUE) && !m_done_i) begin
                  r_state   <= S_WAIT_DONE;
                  m_start_o <= 1'b0;
               end else if ((r_state == S_WAIT_DONE) && m_done_i) begin
                  r_state      <= S_RESP;
                  rsp_data_o   <= m_rx_i;
                  rsp_err_o    <= 1'b0;
                  rsp0_valid_o <= ~r_gnt_id;
                  rsp1_valid_o <= r_gnt_id;
               end
            end
            S_RESP: begin
               r_state   <= S_GAP;
               r_gap_cnt <= 16'd0;
            end
            S_GAP: begin
               if (r_gap_cnt == GAP_LAST) begin
                  r_state <= S_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 16'd1;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               m_start_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/spi_cmd_scheduler.md
SPI_CMD_SCHEDULER -- requirements
Module: spi_cmd_scheduler

Interface
REQ-001 Parameters SHALL be, one per line:
- TIMEOUT_CYCLES, 4096, spi_clk_i cycles allowed in ISSUE+WAIT_DONE before abort (16-bit).
- GAP_CYCLES, 4, idle cycles forced between transactions (min 1).

REQ-002 Ports SHALL be, one per line:
- spi_clk_i  in  1  system clock, rising edge.
- spi_rst_i  in  1  reset, asynchronous, active-low.
- req0_valid_i  in  1  requester 0 command pending.
- req0_data_i  in  48  requester 0 transmit word.
- req0_div_i  in  2  requester 0 SCK divider code.
- req0_fbo_i  in  1  requester 0 bit order (1=MSB first).
- req0_ack_o  out  1  one-cycle pulse: requester 0 command captured.
- req1_valid_i, req1_data_i, req1_div_i, req1_fbo_i, req1_ack_o  same as requester 0.
- rsp0_valid_o  out  1  one-cycle pulse: response for requester 0.
- rsp1_valid_o  out  1  one-cycle pulse: response for requester 1.
- rsp_data_o  out  48  received word, valid with rspN_valid_o.
- rsp_err_o  out  1  timeout flag, valid with rspN_valid_o.
- m_start_o  out  1  start to SPI master.
- m_data_o  out  48  transmit word to SPI master.
- m_div_o  out  2  divider code to SPI master.
- m_fbo_o  out  1  bit order to SPI master.
- m_done_i  in  1  SPI master done (level).
- m_rx_i  in  48  SPI master received word.
- busy_o  out  1  high in any state except IDLE.

Function
REQ-003 The block SHALL be a FSM with states IDLE, ISSUE, WAIT_DONE, RESP, GAP, all registers on rising spi_clk_i.
REQ-004 In IDLE with one reqN_valid_i high, the block SHALL grant that requester and move to ISSUE next cycle.
REQ-005 In IDLE with both requests high, the block SHALL grant the requester not granted last (round-robin); after reset, requester 0 SHALL win the first tie.
REQ-006 On grant, the block SHALL register data/div/fbo into m_data_o/m_div_o/m_fbo_o and pulse reqN_ack_o for exactly one cycle. Requesters SHALL hold inputs stable from valid until ack.
REQ-007 m_data_o, m_div_o and m_fbo_o SHALL remain constant from grant until the following return to IDLE.
REQ-008 In ISSUE, m_start_o SHALL be 1. The block SHALL move to WAIT_DONE on the first cycle m_done_i is sampled 0 (master accepted).
REQ-009 In WAIT_DONE, m_start_o SHALL be 0. The block SHALL move to RESP on the first cycle m_done_i is sampled 1.
REQ-010 Entering RESP normally, the block SHALL capture m_rx_i into rsp_data_o and clear rsp_err_o.
REQ-011 A 16-bit timeout counter SHALL clear on grant and increment each cycle in ISSUE/WAIT_DONE. On reaching TIMEOUT_CYCLES-1, the block SHALL go to RESP with rsp_err_o=1 and rsp_data_o=48'hFFFFFFFFFFFF, and m_start_o SHALL drop.
REQ-012 RESP SHALL last one cycle and pulse rspN_valid_o only for the granted requester. rsp_data_o/rsp_err_o SHALL hold until the next RESP.
REQ-013 GAP SHALL last exactly GAP_CYCLES cycles, then go to IDLE. Requests are ignored in ISSUE through GAP.
REQ-014 Grant-to-rspN_valid_o latency SHALL be (cycles until m_done_i low) + (cycles until m_done_i high) + 2.
REQ-015 A requester dropping valid after ack SHALL NOT affect the transaction in flight.
REQ-016 req0_ack_o/req1_ack_o SHALL never be high together; rsp0_valid_o/rsp1_valid_o SHALL never be high together.

Reset
REQ-017 spi_rst_i low SHALL force IDLE immediately, with all outputs 0 except rsp_data_o=48'hFFFFFFFFFFFF, and the round-robin pointer set to favour requester 0.
REQ-018 Reset mid-transaction SHALL abort with no ack or response pulse, and m_start_o SHALL drop asynchronously.
REQ-019 After reset release, the first grant SHALL occur no earlier than the second rising edge.

Verification
REQ-020 Single request: req0 data 48'h123456789ABC, div 2'b01, master done low at +2, high at +100 -> one req0_ack_o, m_data_o=48'h123456789ABC for the whole transaction, rsp0_valid_o with m_rx_i value, rsp_err_o=0.
REQ-021 Simultaneous req0/req1 held for three transactions after reset -> grant order 0,1,0; GAP_CYCLES idle cycles between m_start_o assertions.
REQ-022 m_done_i stuck 1 with TIMEOUT_CYCLES=16 -> response exactly 16 cycles after entering ISSUE, rsp_err_o=1, rsp_data_o=48'hFFFFFFFFFFFF, m_start_o=0.
REQ-023 spi_rst_i low during WAIT_DONE -> outputs at reset values in the same cycle, no rspN_valid_o; a fresh req1 after release completes normally.
REQ-024 req1 arriving during req0 GAP -> req1 granted on the first IDLE cycle; rsp1_valid_o only; rsp_data_o from req0 held until then.
